// File: rtl/freq_ratio_detector.sv
// Measures the period and high time of a slow clock in reference-clock cycles,
// and flags lock, period changes and missing edges.
module freq_ratio_detector #(
    parameter int CNT_W      = 8,
    parameter int LOCK_COUNT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             locked,
    output logic             mismatch,
    output logic             timeout
);

    localparam int               MW       = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [MW-1:0]    LOCK_VAL = MW'(LOCK_COUNT);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

    state_t           r_state, w_next;
    logic             r_s1, r_s2, r_s3;
    logic [1:0]       r_prime;
    logic [CNT_W-1:0] r_cnt, r_hcnt, r_period, r_high;
    logic [MW-1:0]    r_match;
    logic             r_valid, r_locked, r_mismatch, r_timeout;

    logic             w_rise, w_start, w_done, w_tmo, w_same, w_mism;
    logic [MW-1:0]    w_match_nxt;

    assign w_rise = r_s2 & ~r_s3;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // r_prime keeps IDLE from trusting the synchronizer's reset zeros as a real low.
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_done  = 1'b0;
        w_tmo   = 1'b0;
        case (r_state)
            IDLE:    if (r_prime[1] && !r_s2) w_next = ARM;
            ARM:     if (w_rise) begin
                         w_start = 1'b1;
                         w_next  = MEASURE;
                     end
            MEASURE: if (w_rise) begin
                         w_done = 1'b1;
                     end else if (r_cnt == CNT_MAX) begin
                         w_tmo  = 1'b1;
                         w_next = IDLE;
                     end
            default: w_next = IDLE;
        endcase
    end

    // r_period doubles as the previous-period register; r_match == 0 means no previous.
    always_comb begin
        w_same = (r_cnt == r_period);
        w_mism = (r_match != '0) && !w_same;
        if (r_match == '0 || !w_same) w_match_nxt = MW'(1);
        else if (r_match == LOCK_VAL) w_match_nxt = LOCK_VAL;
        else                          w_match_nxt = r_match + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_s3       <= 1'b0;
            r_prime    <= 2'b00;
            r_cnt      <= '0;
            r_hcnt     <= '0;
            r_period   <= '0;
            r_high     <= '0;
            r_match    <= '0;
            r_valid    <= 1'b0;
            r_locked   <= 1'b0;
            r_mismatch <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_s1       <= sig_in;
            r_s2       <= r_s1;
            r_s3       <= r_s2;
            r_prime    <= {r_prime[0], 1'b1};
            r_valid    <= w_done;
            r_timeout  <= w_tmo;
            r_mismatch <= w_done & w_mism;
            if (w_start || w_done) begin
                r_cnt  <= CNT_ONE;
                r_hcnt <= CNT_ONE;
            end else if (r_state == MEASURE && !w_tmo) begin
                r_cnt  <= r_cnt + 1'b1;
                r_hcnt <= r_hcnt + {{(CNT_W-1){1'b0}}, r_s2};
            end
            if (w_done) begin
                r_period <= r_cnt;
                r_high   <= r_hcnt;
                r_match  <= w_match_nxt;
                r_locked <= (w_match_nxt == LOCK_VAL);
            end else if (w_tmo) begin
                r_match  <= '0;
                r_locked <= 1'b0;
            end
        end
    end

    assign period    = r_period;
    assign high_time = r_high;
    assign valid     = r_valid;
    assign locked    = r_locked;
    assign mismatch  = r_mismatch;
    assign timeout   = r_timeout;

endmodule
